prog_timer: RTL

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/prog_timer.sv
// Programmable tick-driven timer: one-shot or periodic, with a saturating expiry counter.
// Counts tick strobes from load_value down to 1. Flags each expiry and then either reloads or returns to idle.
module prog_timer #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tick,
    input  logic            start,
    input  logic            stop,
    input  logic            mode,
    input  logic [BITS-1:0] load_value,
    output logic [BITS-1:0] count,
    output logic            busy,
    output logic            expired,
    output logic [7:0]      expire_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [BITS-1:0]    count_q, count_nxt;
    logic [BITS-1:0]    period_q, period_nxt;
    logic               mode_q, mode_nxt;
    logic               expired_q, expired_nxt;
    logic [CNT_W-1:0]   ecnt_q, ecnt_nxt;
    logic               load_nz;

    assign load_nz = (load_value != '0);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
            ecnt_q    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            period_q  <= period_nxt;
            mode_q    <= mode_nxt;
            expired_q <= expired_nxt;
            ecnt_q    <= ecnt_nxt;
            busy      <= (state_nxt == RUN);
        end
    end

    // Next-state logic; priority is stop > start > tick
    always_comb begin
        state_nxt   = state;
        count_nxt   = count_q;
        period_nxt  = period_q;
        mode_nxt    = mode_q;
        expired_nxt = 1'b0;
        ecnt_nxt    = ecnt_q;

        unique case (state)
            IDLE: begin
                if (start && load_nz) begin
                    state_nxt  = RUN;
                    count_nxt  = load_value;
                    period_nxt = load_value;
                    mode_nxt   = mode;
                    ecnt_nxt   = '0;
                end
            end
            RUN: begin
                if (stop || (start && !load_nz)) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (start) begin
                    count_nxt  = load_value;
                    period_nxt = load_value;
                    mode_nxt   = mode;
                end else if (tick) begin
                    if (count_q > BITS'(1)) begin
                        count_nxt = count_q - BITS'(1);
                    end else if (count_q == BITS'(1)) begin
                        expired_nxt = 1'b1;
                        if (ecnt_q != {CNT_W{1'b1}}) begin
                            ecnt_nxt = ecnt_q + CNT_W'(1);
                        end
                        // Periodic reload lands on the expiry tick itself, so no tick is lost
                        if (mode_q) begin
                            count_nxt = period_q;
                        end else begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign count      = count_q;
    assign expired    = expired_q;
    assign expire_cnt = ecnt_q;

endmodule
